// File: rtl/round_col_engine.sv
// round_col_engine: column-serial AES-128 round datapath.
// Drives the ShiftRows selector's column index, takes one shifted column per
// cycle, applies SubBytes / MixColumns / AddRoundKey, and commits the full
// 128-bit state in one write at the end of the fourth column.
module round_col_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] load_data,
    input  logic         start,
    input  logic         first_round,
    input  logic         last_round,
    input  logic [127:0] round_key,
    input  logic [7:0]   in_1,
    input  logic [7:0]   in_2,
    input  logic [7:0]   in_3,
    input  logic [7:0]   in_4,
    output logic [2:0]   col_idx,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_COL  = 1'b1
    } fsm_t;

    // GF(2^8) multiply by 2, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One MixColumns column; row 0 sits in the MSB byte.
    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                xtime(a1) ^ xtime(a2) ^ a2 ^ a3 ^ a0,
                xtime(a2) ^ xtime(a3) ^ a3 ^ a0 ^ a1,
                xtime(a3) ^ xtime(a0) ^ a0 ^ a1 ^ a2};
    endfunction

    // FIPS-197 forward S-box.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        case (a)
            8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
            8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
            8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
            8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
            8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
            8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
            8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
            8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
            8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
            8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
            8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
            8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
            8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
            8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
            8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
            8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
            8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
            8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
            8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
            8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
            8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
            8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
            8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
            8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
            8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
            8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
            8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
            8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
            8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
            8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
            8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
            8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
            default: sbox = 8'h00;
        endcase
    endfunction

    fsm_t         r_fsm;
    logic [1:0]   r_col;
    logic [31:0]  r_buf0;
    logic [31:0]  r_buf1;
    logic [31:0]  r_buf2;
    logic [127:0] r_state_out;
    logic         r_busy;
    logic         r_done;

    logic [31:0]  w_col;
    logic [31:0]  w_sub;
    logic [31:0]  w_mix;
    logic [31:0]  w_res;
    logic [31:0]  w_key_col;
    logic [31:0]  w_new_col;

    assign w_col = {in_1, in_2, in_3, in_4};
    assign w_sub = {sbox(in_1), sbox(in_2), sbox(in_3), sbox(in_4)};
    assign w_mix = mix_col(w_sub);

    // Per-column round transform and key column selection.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_res     = w_mix;
        w_key_col = round_key[127:96];
        if (first_round) begin
            w_res = w_col;
        end else if (last_round) begin
            w_res = w_sub;
        end
        case (r_col)
            2'd0:    w_key_col = round_key[127:96];
            2'd1:    w_key_col = round_key[95:64];
            2'd2:    w_key_col = round_key[63:32];
            default: w_key_col = round_key[31:0];
        endcase
    end

    assign w_new_col = w_res ^ w_key_col;

    // Control FSM, column buffer and state register; state_out only changes on load or final commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_fsm       <= S_IDLE;
            r_col       <= 2'd0;
            r_buf0      <= 32'd0;
            r_buf1      <= 32'd0;
            r_buf2      <= 32'd0;
            r_state_out <= 128'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (load) begin
                        r_state_out <= load_data;
                    end else if (start) begin
                        r_fsm  <= S_COL;
                        r_col  <= 2'd0;
                        r_busy <= 1'b1;
                    end
                end
                S_COL: begin
                    case (r_col)
                        2'd0:    r_buf0 <= w_new_col;
                        2'd1:    r_buf1 <= w_new_col;
                        2'd2:    r_buf2 <= w_new_col;
                        default: ;
                    endcase
                    if (r_col == 2'd3) begin
                        // Last column goes straight into the state so the whole round commits atomically.
                        r_state_out <= {r_buf0, r_buf1, r_buf2, w_new_col};
                        r_fsm       <= S_IDLE;
                        r_col       <= 2'd0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_col <= r_col + 2'd1;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign col_idx   = {1'b0, r_col};
    assign state_out = r_state_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_round_col_engine.sv
// tb_round_col_engine: directed bench for round_col_engine with a ShiftRows
// selector model feeding the column bytes back from state_out.
module tb_round_col_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [127:0] load_data;
    logic         start;
    logic         first_round;
    logic         last_round;
    logic [127:0] round_key;
    logic [7:0]   in_1, in_2, in_3, in_4;
    logic [2:0]   col_idx;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    // Column-0 override used to inject hand-picked bytes.
    logic         ovr_en;
    logic [31:0]  ovr_col;

    int n_checks = 0;
    int n_errors = 0;

    round_col_engine dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_data   (load_data),
        .start       (start),
        .first_round (first_round),
        .last_round  (last_round),
        .round_key   (round_key),
        .in_1        (in_1),
        .in_2        (in_2),
        .in_3        (in_3),
        .in_4        (in_4),
        .col_idx     (col_idx),
        .state_out   (state_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ShiftRows selector: row r of output column c is state byte (row r, column (c+r) mod 4);
    // in round 0 the selector passes columns through unshifted.
    function automatic logic [7:0] sel_byte(input logic [127:0] s, input logic [1:0] c,
                                            input logic fr, input logic [1:0] r);
        logic [1:0]   sc;
        logic [127:0] t;
        sc = fr ? c : c + r;
        t  = s << (32 * int'(sc) + 8 * int'(r));
        return t[127:120];
    endfunction

    logic w_ovr;
    assign w_ovr = ovr_en && (col_idx[1:0] == 2'd0);
    assign in_1 = w_ovr ? ovr_col[31:24] : sel_byte(state_out, col_idx[1:0], first_round, 2'd0);
    assign in_2 = w_ovr ? ovr_col[23:16] : sel_byte(state_out, col_idx[1:0], first_round, 2'd1);
    assign in_3 = w_ovr ? ovr_col[15:8]  : sel_byte(state_out, col_idx[1:0], first_round, 2'd2);
    assign in_4 = w_ovr ? ovr_col[7:0]   : sel_byte(state_out, col_idx[1:0], first_round, 2'd3);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_state(input logic [127:0] d);
        load      = 1'b1;
        load_data = d;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Runs one round; returns at the negedge where done is high (or after the cycle budget).
    task automatic do_round(input logic fr, input logic lr, input logic [127:0] key,
                            input logic [127:0] prev);
        int n;
        first_round = fr;
        last_round  = lr;
        round_key   = key;
        start       = 1'b1;
        @(posedge clk);
        n = 1;
        #1 start = 1'b0;
        while (n < 20) begin
            @(negedge clk);
            if (done) break;
            check("col_idx_step", 128'(col_idx), 128'(n - 1));
            check("busy_in_col", 128'(busy), 128'd1);
            check("state_held", state_out, prev);
            @(posedge clk);
            n++;
        end
        check("latency", 128'(n), 128'd5);
        check("busy_at_done", 128'(busy), 128'd0);
        check("col_idx_at_done", 128'(col_idx), 128'd0);
    endtask

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R0     = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] K1     = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] R1     = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] S10    = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] K10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] R10    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R_MC   = 128'h8e4da1bc636363636363636363636363;
    localparam logic [127:0] JUNK   = 128'hffeeddccbbaa99887766554433221100;

    initial begin
        int n_done;
        rst = 1'b1; load = 1'b0; load_data = '0; start = 1'b0;
        first_round = 1'b0; last_round = 1'b0; round_key = '0;
        ovr_en = 1'b0; ovr_col = '0;

        // Reset state
        #12;
        check("rst_state", state_out, 128'd0);
        check("rst_col_idx", 128'(col_idx), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: load, then round 0 (AddRoundKey only)
        load_state(PT);
        check("load_value", state_out, PT);
        do_round(1'b1, 1'b0, K0, PT);
        check("round0_result", state_out, R0);

        // 2: back-to-back middle round, start driven in the done cycle
        do_round(1'b0, 1'b0, K1, R0);
        check("round1_result", state_out, R1);

        // 3: last round skips MixColumns
        @(posedge clk);
        #1;
        load_state(S10);
        do_round(1'b0, 1'b1, K10, S10);
        check("round10_result", state_out, R10);

        // 4: injected column 0 = S-box preimages of db,13,53,45 over a zero state, zero key
        @(posedge clk);
        #1;
        load_state(128'd0);
        ovr_en  = 1'b1;
        ovr_col = 32'h9f825068;
        do_round(1'b0, 1'b0, 128'd0, 128'd0);
        check("mixcol_col0", 128'(state_out[127:96]), 128'h8e4da1bc);
        check("mixcol_full", state_out, R_MC);
        ovr_en = 1'b0;

        // 5: start held through COL, load pulsed in COL cycle 2 -> ignored
        @(posedge clk);
        #1;
        load_state(S10);
        n_done      = 0;
        first_round = 1'b0;
        last_round  = 1'b1;
        round_key   = K10;
        start       = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            start     = 1'b1;
            load      = (k == 2);
            load_data = JUNK;
            @(negedge clk);
            if (done) n_done++;
            check("ign_col_idx", 128'(col_idx), 128'(k));
            check("ign_state_held", state_out, S10);
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        load  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (k == 0) begin
                check("ign_done_now", 128'(done), 128'd1);
                check("ign_col_idx_wrap", 128'(col_idx), 128'd0);
                check("ign_result", state_out, R10);
            end
        end
        check("ign_one_done", 128'(n_done), 128'd1);

        // 6: reset in COL cycle 2 aborts the round
        @(posedge clk);
        #1;
        load_state(PT);
        first_round = 1'b0;
        last_round  = 1'b0;
        round_key   = K1;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_state", state_out, 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_col_idx", 128'(col_idx), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 128'(n_done), 128'd0);

        // load + start in the same IDLE cycle: load wins, no round starts
        @(posedge clk);
        #1;
        load      = 1'b1;
        start     = 1'b1;
        load_data = JUNK;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("ldst_state", state_out, JUNK);
        check("ldst_idle", 128'(n_done), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
